// File: rtl/mag_search_pkg.sv
// Shared state encoding and overflow-safe midpoint helper for the binary-search initiator.
// Pure declarations; no timing or flow-control behaviour of its own.
package mag_search_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_PROBE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Widest probe value the helper supports; callers zero-extend into it.
    localparam int MID_W = 32;

    // One spare bit keeps lo + (hi - lo) / 2 exact even when hi is all-ones.
    function automatic logic [MID_W:0] midpoint(input logic [MID_W-1:0] lo,
                                                input logic [MID_W-1:0] hi);
        logic [MID_W:0] lo_x;
        logic [MID_W:0] hi_x;
        lo_x = {1'b0, lo};
        hi_x = {1'b0, hi};
        return lo_x + ((hi_x - lo_x) >> 1);
    endfunction

endpackage

// File: rtl/mag_search_if.sv
// Probe/response link between the search initiator (master) and a comparator (slave).
// Probe is held until rsp_vld; the responder may stall indefinitely.
interface mag_search_if #(
    parameter int W = 8
);
    logic [W-1:0] guess;
    logic         guess_vld;
    logic         rsp_vld;
    logic         grt;
    logic         lst;
    logic         equ;

    modport master (
        output guess,
        output guess_vld,
        input  rsp_vld,
        input  grt,
        input  lst,
        input  equ
    );

    modport slave (
        input  guess,
        input  guess_vld,
        output rsp_vld,
        output grt,
        output lst,
        output equ
    );
endinterface

// File: rtl/mag_cmp_resp.sv
// Comparator responder: answers each probe against a target after a programmable wait, optional forced flags.
// Latency: 'latency' cycles after guess_vld rises (0 = same cycle); holds off by keeping rsp_vld low.
module mag_cmp_resp #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] target,
    input  logic [7:0]   latency,
    input  logic         fault_en,
    input  logic [2:0]   fault_flags,
    mag_search_if.slave  cmp
);
    logic [7:0] wait_q;
    logic [7:0] wait_d;
    logic [2:0] true_flags;
    logic [2:0] out_flags;

    // Counter restarts whenever the probe drops, so each new probe waits afresh.
    always_comb begin
        wait_d = wait_q + 8'd1;
        if (!cmp.guess_vld || cmp.rsp_vld) begin
            wait_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_q <= 8'd0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign true_flags  = {target > cmp.guess, target < cmp.guess, target == cmp.guess};
    assign out_flags   = fault_en ? fault_flags : true_flags;
    assign cmp.rsp_vld = cmp.guess_vld && (wait_q >= latency);
    assign cmp.grt     = out_flags[2];
    assign cmp.lst     = out_flags[1];
    assign cmp.equ     = out_flags[0];

endmodule

// File: rtl/mag_search.sv
// Binary-search initiator: probes a comparator with midpoints until it reports equality or an inconsistency.
// Latency: 2 cycles per probe plus responder wait, done 1 cycle after final response; stalls while rsp_vld is low.
module mag_search
    import mag_search_pkg::*;
#(
    parameter int W  = 8,
    parameter int SW = $clog2(W + 2)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    mag_search_if.master  cmp,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  found,
    output logic [SW-1:0] steps,
    output logic          err
);
    state_e        state_q;
    logic [W-1:0]  lo_q;
    logic [W-1:0]  hi_q;
    logic [W-1:0]  guess_q;
    logic [SW-1:0] steps_q;
    logic [W-1:0]  found_q;
    logic          err_q;
    logic          vld_q;
    logic          busy_q;
    logic          done_q;

    logic [W-1:0]  guess_d;
    logic [W-1:0]  lo_d;
    logic [W-1:0]  hi_d;
    logic [2:0]    rsp_flags;

    assign guess_d   = W'(midpoint(MID_W'(lo_q), MID_W'(hi_q)));
    assign lo_d      = guess_q + W'(1);
    assign hi_d      = guess_q - W'(1);
    assign rsp_flags = {cmp.grt, cmp.lst, cmp.equ};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lo_q    <= '0;
            hi_q    <= '1;
            guess_q <= '0;
            steps_q <= '0;
            found_q <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        lo_q    <= '0;
                        hi_q    <= '1;
                        steps_q <= '0;
                        err_q   <= 1'b0;
                        found_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    guess_q <= guess_d;
                    steps_q <= steps_q + SW'(1);
                    vld_q   <= 1'b1;
                    state_q <= ST_PROBE;
                end
                ST_PROBE: begin
                    if (cmp.rsp_vld) begin
                        vld_q <= 1'b0;
                        // A narrowing step that would empty the range means the responder contradicted itself.
                        case (rsp_flags)
                            3'b001: begin
                                found_q <= guess_q;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end
                            3'b100: begin
                                if (guess_q == '1 || lo_d > hi_q) begin
                                    err_q   <= 1'b1;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    state_q <= ST_DONE;
                                end else begin
                                    lo_q    <= lo_d;
                                    state_q <= ST_CALC;
                                end
                            end
                            3'b010: begin
                                if (guess_q == '0 || hi_d < lo_q) begin
                                    err_q   <= 1'b1;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    state_q <= ST_DONE;
                                end else begin
                                    hi_q    <= hi_d;
                                    state_q <= ST_CALC;
                                end
                            end
                            default: begin
                                err_q   <= 1'b1;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmp.guess     = guess_q;
    assign cmp.guess_vld = vld_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign found         = found_q;
    assign steps         = steps_q;
    assign err           = err_q;

endmodule

// File: tb/tb_mag_search.sv
// Bench for mag_search: directed and random searches against a responder, checked with an arithmetic search model.
module tb_mag_search;
    localparam int W   = 8;
    localparam int SW  = $clog2(W + 2);
    localparam int W2  = 2;
    localparam int SW2 = $clog2(W2 + 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          err;
    logic [W-1:0]  found;
    logic [SW-1:0] steps;
    logic [W-1:0]  target;
    logic [7:0]    latency;
    logic          fault_en;
    logic [2:0]    fault_flags;

    logic           start2;
    logic           busy2;
    logic           done2;
    logic           err2;
    logic [W2-1:0]  found2;
    logic [SW2-1:0] steps2;
    logic [W2-1:0]  target2;
    logic [7:0]     latency2;
    logic           fault_en2;
    logic [2:0]     fault_flags2;

    mag_search_if #(.W(W))  bus ();
    mag_search_if #(.W(W2)) bus2 ();

    mag_search #(.W(W), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmp(bus.master),
        .busy(busy), .done(done), .found(found), .steps(steps), .err(err)
    );
    mag_cmp_resp #(.W(W)) resp (
        .clk(clk), .rst_n(rst_n), .target(target), .latency(latency),
        .fault_en(fault_en), .fault_flags(fault_flags), .cmp(bus.slave)
    );
    mag_search #(.W(W2), .SW(SW2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cmp(bus2.master),
        .busy(busy2), .done(done2), .found(found2), .steps(steps2), .err(err2)
    );
    mag_cmp_resp #(.W(W2)) resp2 (
        .clk(clk), .rst_n(rst_n), .target(target2), .latency(latency2),
        .fault_en(fault_en2), .fault_flags(fault_flags2), .cmp(bus2.slave)
    );

    int n_chk = 0;
    int n_err = 0;
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: interval halving on plain integers, honouring forced flags.
    task automatic model(input int w, input int tgt, input bit frc, input bit [2:0] fl,
                         output int f, output int s, output bit e);
        int lo, hi, g, top;
        bit [2:0] r;
        bit fin;
        top = (1 << w) - 1;
        lo = 0; hi = top; f = 0; s = 0; e = 0; fin = 0;
        exp_q.delete();
        while (!fin && s < 64) begin
            g = (lo + hi) / 2;
            s++;
            exp_q.push_back(g);
            r = frc ? fl : {tgt > g, tgt < g, tgt == g};
            fin = 1;
            if (r == 3'b001) f = g;
            else if (r == 3'b100 && g < top) begin lo = g + 1; fin = (lo > hi); e = fin; end
            else if (r == 3'b010 && g > 0)   begin hi = g - 1; fin = (lo > hi); e = fin; end
            else e = 1;
        end
    endtask

    // Probe log plus guess-stability and inter-probe gap tracking.
    int           probes_q[$];
    int           moved_cnt = 0;
    int           bad_gap = 0;
    int           low_run = 0;
    logic         prev_vld = 1'b0;
    logic         prev_rsp = 1'b0;
    logic [W-1:0] prev_guess = '0;

    always @(negedge clk) begin
        if (bus.guess_vld && bus.rsp_vld) probes_q.push_back(int'(bus.guess));
        if (bus.guess_vld && prev_vld && !prev_rsp && bus.guess !== prev_guess) moved_cnt <= moved_cnt + 1;
        if (bus.guess_vld && !prev_vld && low_run != 1) bad_gap <= bad_gap + 1;
        if (bus.guess_vld || !busy) low_run <= 0;
        else low_run <= low_run + 1;
        prev_vld   <= bus.guess_vld;
        prev_rsp   <= bus.rsp_vld;
        prev_guess <= bus.guess;
    end

    task automatic run8(input int tgt, input int lat, input bit frc, input bit [2:0] fl,
                        input bit poke, input string tag);
        int m_found, m_steps, base, gb, mb, cyc;
        bit m_err;
        target = W'(tgt); latency = 8'(lat); fault_en = frc; fault_flags = fl;
        model(W, tgt, frc, fl, m_found, m_steps, m_err);
        base = probes_q.size(); gb = bad_gap; mb = moved_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk({tag, " busy_calc"}, busy, 1);
        chk({tag, " vld_calc"}, bus.guess_vld, 0);
        while (!done && cyc < 3000) begin
            if (poke && bus.guess_vld) begin start = 1'b1; poke = 1'b0; end
            else start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, done, 1);
        chk({tag, " cycles"}, cyc, m_steps * (lat + 2) + 1);
        chk({tag, " found"}, found, m_found);
        chk({tag, " steps"}, steps, m_steps);
        chk({tag, " err"}, err, m_err);
        chk({tag, " busy_done"}, busy, 0);
        chk({tag, " nprobes"}, probes_q.size() - base, exp_q.size());
        foreach (exp_q[i])
            chk({tag, " probe"}, (base + i < probes_q.size()) ? probes_q[base + i] : -1, exp_q[i]);
        chk({tag, " gaps"}, bad_gap - gb, 0);
        chk({tag, " stable"}, moved_cnt - mb, 0);
        @(negedge clk);
        chk({tag, " done_pulse"}, done, 0);
        chk({tag, " found_hold"}, found, m_found);
    endtask

    task automatic run2(input int tgt);
        int m_found, m_steps, cyc;
        bit m_err;
        target2 = W2'(tgt);
        model(W2, tgt, 1'b0, 3'b000, m_found, m_steps, m_err);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 1;
        while (!done2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("w2 done_seen", done2, 1);
        chk("w2 found", found2, tgt);
        chk("w2 steps", steps2, m_steps);
        chk("w2 steps_max", (steps2 <= 3), 1);
        chk("w2 err", err2, 0);
        @(negedge clk);
    endtask

    initial begin
        int p37[7];
        int base, k, tgt, lat;
        p37 = '{127, 63, 31, 47, 39, 35, 37};
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        target = '0; latency = 8'd0; fault_en = 1'b0; fault_flags = 3'b000;
        target2 = '0; latency2 = 8'd0; fault_en2 = 1'b0; fault_flags2 = 3'b000;
        repeat (3) @(negedge clk);
        chk("rst guess", bus.guess, 0);
        chk("rst vld", bus.guess_vld, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst found", found, 0);
        chk("rst steps", steps, 0);
        chk("rst busy2", busy2, 0);
        rst_n = 1'b1;
        @(negedge clk);

        base = probes_q.size();
        run8(37, 0, 1'b0, 3'b000, 1'b0, "t37");
        foreach (p37[i])
            chk("t37 spec_probe", (base + i < probes_q.size()) ? probes_q[base + i] : -1, p37[i]);
        run8(255, 0, 1'b0, 3'b000, 1'b0, "t255");
        run8(0, 0, 1'b0, 3'b000, 1'b0, "t0");
        run8(200, 3, 1'b0, 3'b000, 1'b1, "t200");

        run8(90, 0, 1'b1, 3'b101, 1'b0, "f_grt_equ");
        run8(0, 1, 1'b1, 3'b010, 1'b0, "f_lst_zero");
        run8(255, 0, 1'b1, 3'b100, 1'b0, "f_grt_top");
        run8(17, 2, 1'b1, 3'b000, 1'b0, "f_none");

        for (int r = 0; r < 8; r++) begin
            tgt = int'($urandom_range(255, 0));
            lat = int'($urandom_range(3, 0));
            run8(tgt, lat, 1'b0, 3'b000, 1'b0, "rand");
        end

        // Abort during the third probe.
        target = W'(100); latency = 8'd2; fault_en = 1'b0;
        base = probes_q.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(probes_q.size() - base >= 2 && bus.guess_vld) && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("mid third_probe", (probes_q.size() - base >= 2 && bus.guess_vld), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid guess", bus.guess, 0);
        chk("mid vld", bus.guess_vld, 0);
        chk("mid busy", busy, 0);
        chk("mid done", done, 0);
        chk("mid err", err, 0);
        chk("mid found", found, 0);
        chk("mid steps", steps, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run8(5, 1, 1'b0, 3'b000, 1'b0, "after_rst");

        for (int t = 0; t < 4; t++) run2(t);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
